// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and the data memory port.
// Issues one or two word-aligned, byte-enabled memory transactions per
// load/store. Accesses that straddle a word boundary are split in two.
// Load results are sign- or zero-extended into rd.
module lsu_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ0, REQ1, RESP} state_t;

    localparam logic [DM_ADDRESS-1:0] WORD_STEP = DM_ADDRESS'(4);

    state_t state;

    // Per-access context captured when the instruction is accepted
    logic                  we_q;
    logic [2:0]            funct_q;
    logic [1:0]            off_q;
    logic [DATA_W-1:0]     wd_q;
    logic [2:0]            mask_hi_q;
    logic                  split_q;
    logic [DATA_W-1:0]     rdata0_q;

    logic                  req_in;
    logic                  illegal_in;
    logic [3:0]            base_mask;
    logic [6:0]            mask_in;
    logic [DATA_W-1:0]     wdata0_in;
    logic [DATA_W-1:0]     wdata1;
    logic [5:0]            byte_sh;
    logic [DATA_W-1:0]     raw;

    // Sign/zero extension of the lane-aligned load bytes
    function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f,
                                                   input logic [DATA_W-1:0] v);
        case (f)
            3'b000:  load_ext = {{(DATA_W-8){v[7]}}, v[7:0]};
            3'b001:  load_ext = {{(DATA_W-16){v[15]}}, v[15:0]};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, v[7:0]};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, v[15:0]};
            default: load_ext = v;
        endcase
    endfunction

    assign req_in     = MemRead | MemWrite;
    // Read wins when both are requested, so legality follows the load rules then
    assign illegal_in = MemRead ? ((Funct3 == 3'b011) || (Funct3[2:1] == 2'b11))
                                : (Funct3 > 3'b010);

    // Lane mask for the incoming access; bits 6:4 spill into the next word
    always_comb begin
        case (Funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask_in = {3'b000, base_mask} << addr[1:0];
    end

    assign wdata0_in = wd << {addr[1:0], 3'b000};
    assign byte_sh   = {1'b0, off_q, 3'b000};
    // Only used when split, so off_q is 1..3 and the shift is 24/16/8
    assign wdata1    = wd_q >> (6'd32 - byte_sh);

    // Reassemble the loaded bytes; the second word only contributes on a split
    always_comb begin
        if (state == REQ1)
            raw = (rdata0_q >> byte_sh) | (mem_rdata << (6'd32 - byte_sh));
        else
            raw = mem_rdata >> byte_sh;
    end

    // Pipeline freezes combinationally in the request cycle and while transacting
    assign stall = rst_n & (((state == IDLE) & req_in) | (state == REQ0) | (state == REQ1));

    // Access context and first read word; no reset needed on pure data
    always_ff @(posedge clk) begin
        if (state == IDLE && req_in) begin
            we_q      <= ~MemRead;
            funct_q   <= Funct3;
            off_q     <= addr[1:0];
            wd_q      <= wd;
            mask_hi_q <= mask_in[6:4];
            split_q   <= |mask_in[6:4];
        end
        if (state == REQ0 && mem_ready) begin
            rdata0_q <= mem_rdata;
        end
    end

    // Access sequencer with registered memory-port and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            rd        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_in) begin
                        if (illegal_in) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ0;
                            mem_req   <= 1'b1;
                            mem_we    <= ~MemRead;
                            mem_addr  <= {addr[DM_ADDRESS-1:2], 2'b00};
                            mem_be    <= mask_in[3:0];
                            mem_wdata <= MemRead ? '0 : wdata0_in;
                        end
                    end
                end
                REQ0: begin
                    if (mem_ready) begin
                        if (split_q) begin
                            state     <= REQ1;
                            mem_addr  <= mem_addr + WORD_STEP;
                            mem_be    <= {1'b0, mask_hi_q};
                            mem_wdata <= we_q ? wdata1 : '0;
                        end else begin
                            state     <= RESP;
                            done      <= 1'b1;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_be    <= 4'b0000;
                            mem_wdata <= '0;
                            if (!we_q) rd <= load_ext(funct_q, raw);
                        end
                    end
                end
                REQ1: begin
                    if (mem_ready) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        if (!we_q) rd <= load_ext(funct_q, raw);
                    end
                end
                default: begin
                    // Instruction is still on the inputs here; do not reissue it
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: byte-addressed memory environment, a byte-level
// reference model of each load/store, per-cycle output comparison, and
// hand-computed literal expectations for the canonical scenarios.
module tb_lsu_ctrl;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic [2:0]    Funct3 = 3'b000;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wd = '0;
    logic          stall, done, err;
    logic [31:0]   rd;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]    mem [512];
    logic [7:0]    shadow [512];
    logic          init_mem = 1'b0;
    logic [31:0]   rd_model = '0;

    logic [AW-1:0] cap_addr [2];
    logic [3:0]    cap_be [2];
    logic [31:0]   cap_wd [2];
    logic          cap_we;
    logic          last_err;

    lsu_ctrl #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .addr(addr), .wd(wd), .stall(stall), .done(done),
        .err(err), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory environment: combinational read, byte-enabled write on transfer
    assign mem_rdata = {mem[int'(mem_addr)+3], mem[int'(mem_addr)+2],
                        mem[int'(mem_addr)+1], mem[int'(mem_addr)]};

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i * 37 + 11);
        end else if (rst_n && mem_req && mem_ready && mem_we) begin
            for (int l = 0; l < 4; l++)
                if (mem_be[l]) mem[int'(mem_addr)+l] <= mem_wdata[8*l +: 8];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // Idle cycles with no request: nothing may move, rd holds
    task automatic idle(input int nc);
        for (int c = 0; c < nc; c++) begin
            MemRead = 1'b0;
            MemWrite = 1'b0;
            Funct3 = 3'($urandom);
            addr = AW'($urandom);
            wd = $urandom;
            mem_ready = 1'($urandom);
            #1;
            chk("idle_stall", stall, 0);
            chk("idle_req", mem_req, 0);
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
            chk("idle_rd", rd, rd_model);
            @(negedge clk);
        end
    endtask

    // One instruction: model derives the transfer list and result from bytes,
    // then every cycle until done the DUT outputs are compared against it.
    task automatic run_op(input bit r, input bit w, input logic [2:0] f,
                          input logic [AW-1:0] a, input logic [31:0] d,
                          input int wait0, input bit rnd_ready, output int lat);
        bit            ld, bad;
        int            n, nx, k, waits, ph;
        logic [AW-1:0] xa [2];
        logic [3:0]    xb [2];
        logic [31:0]   xw [2];
        logic [31:0]   raw, exp_rd;

        ld  = r;
        bad = ld ? (f == 3'b011 || f == 3'b110 || f == 3'b111) : (f > 3'b010);
        n   = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        xa[0] = '0; xa[1] = '0; xb[0] = '0; xb[1] = '0; xw[0] = '0; xw[1] = '0;
        nx = 0;
        raw = '0;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                int ba, kk;
                ba = (int'(a) + i) % 512;
                kk = ((ba & ~3) == (int'(a) & ~3)) ? 0 : 1;
                xa[kk] = AW'(ba & ~3);
                xb[kk][ba % 4] = 1'b1;
                xw[kk][8*(ba % 4) +: 8] = d[8*i +: 8];
                if (kk + 1 > nx) nx = kk + 1;
                raw[8*i +: 8] = shadow[ba];
            end
        end
        case (f)
            3'b000:  exp_rd = {{24{raw[7]}}, raw[7:0]};
            3'b001:  exp_rd = {{16{raw[15]}}, raw[15:0]};
            3'b100:  exp_rd = {24'b0, raw[7:0]};
            3'b101:  exp_rd = {16'b0, raw[15:0]};
            default: exp_rd = raw;
        endcase

        MemRead = r; MemWrite = w; Funct3 = f; addr = a; wd = d;
        ph = 0; k = 0; waits = wait0; lat = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (ph == 1 && waits > 0) begin
                mem_ready = 1'b0;
                waits--;
            end else if (ph == 1 && !rnd_ready) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = ($urandom_range(3) != 0);
            end
            #1;
            chk("stall", stall, ph != 2);
            chk("mem_req", mem_req, ph == 1);
            chk("done", done, ph == 2);
            chk("err", err, ph == 2 && bad);
            chk("rd", rd, rd_model);
            if (ph == 1) begin
                chk("mem_we", mem_we, !ld);
                chk("mem_addr", mem_addr, xa[k]);
                chk("mem_be", mem_be, xb[k]);
                if (!ld)
                    for (int l = 0; l < 4; l++)
                        if (xb[k][l]) chk("mem_wdata_lane", mem_wdata[8*l +: 8], xw[k][8*l +: 8]);
            end
            if (ph == 2) begin
                lat = cyc;
                last_err = err;
                @(negedge clk);
                break;
            end
            if (ph == 0) begin
                ph = bad ? 2 : 1;
            end else if (mem_ready) begin
                cap_addr[k] = mem_addr; cap_be[k] = mem_be; cap_wd[k] = mem_wdata; cap_we = mem_we;
                k++;
                if (k == nx) ph = 2;
            end
            if (ph == 2 && !bad) begin
                if (ld) rd_model = exp_rd;
                else for (int i = 0; i < n; i++) shadow[(int'(a) + i) % 512] = d[8*i +: 8];
            end
            @(negedge clk);
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL op_timeout: got no done expected done within 60 cycles");
        end
    endtask

    initial begin
        int lat;
        logic [7:0] old94;

        for (int i = 0; i < 512; i++) shadow[i] = 8'(i * 37 + 11);
        init_mem = 1'b1;
        MemRead = 1'b1;
        @(negedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        #1;
        chk("reset_rd", rd, 0);
        chk("reset_req", mem_req, 0);
        chk("reset_stall", stall, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_be", mem_be, 0);
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Aligned word store and load
        run_op(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 0, lat);
        chk("sw_lat", lat, 2);
        chk("sw_be", cap_be[0], 4'b1111);
        chk("sw_mem", mem_word(9'h010), 32'hDEADBEEF);
        run_op(1, 0, 3'b010, 9'h010, 32'h0, 0, 0, lat);
        chk("lw_lat", lat, 2);
        chk("lw_rd", rd, 32'hDEADBEEF);

        // Byte lanes and extension
        run_op(0, 1, 3'b010, 9'h020, 32'h80FF7F01, 0, 0, lat);
        run_op(1, 0, 3'b000, 9'h023, 32'h0, 0, 0, lat);
        chk("lb_rd", rd, 32'hFFFFFF80);
        chk("lb_addr", cap_addr[0], 9'h020);
        run_op(1, 0, 3'b100, 9'h023, 32'h0, 0, 0, lat);
        chk("lbu_rd", rd, 32'h00000080);
        run_op(1, 0, 3'b001, 9'h022, 32'h0, 0, 0, lat);
        chk("lh_rd", rd, 32'hFFFF80FF);
        run_op(1, 0, 3'b101, 9'h021, 32'h0, 0, 0, lat);
        chk("lhu_rd", rd, 32'h0000FF7F);
        chk("lhu_addr", cap_addr[0], 9'h020);

        // Split store across a word boundary
        run_op(0, 1, 3'b010, 9'h013, 32'h11223344, 0, 0, lat);
        chk("ssw_lat", lat, 3);
        chk("ssw_addr0", cap_addr[0], 9'h010);
        chk("ssw_be0", cap_be[0], 4'b1000);
        chk("ssw_wd0", cap_wd[0][31:24], 8'h44);
        chk("ssw_addr1", cap_addr[1], 9'h014);
        chk("ssw_be1", cap_be[1], 4'b0111);
        chk("ssw_wd1", cap_wd[1][23:0], 24'h112233);
        chk("ssw_mem", {mem[9'h016], mem[9'h015], mem[9'h014], mem[9'h013]}, 32'h11223344);

        // Split load wrapping past the top of memory
        run_op(0, 1, 3'b000, 9'h1FF, 32'h00000034, 0, 0, lat);
        run_op(0, 1, 3'b000, 9'h000, 32'h00000092, 0, 0, lat);
        run_op(1, 0, 3'b001, 9'h1FF, 32'h0, 0, 0, lat);
        chk("wrap_lat", lat, 3);
        chk("wrap_addr0", cap_addr[0], 9'h1FC);
        chk("wrap_addr1", cap_addr[1], 9'h000);
        chk("wrap_rd", rd, 32'hFFFF9234);

        // Memory wait states during REQ0
        run_op(1, 0, 3'b010, 9'h010, 32'h0, 3, 0, lat);
        chk("wait_lat", lat, 5);
        chk("wait_rd", rd, 32'h44ADBEEF);

        // Read wins when both requests are high
        run_op(1, 1, 3'b010, 9'h020, 32'h12345678, 0, 0, lat);
        chk("both_we", cap_we, 0);
        chk("both_rd", rd, 32'h80FF7F01);

        // Illegal encodings complete at once with err
        run_op(1, 0, 3'b011, 9'h020, 32'h0, 0, 0, lat);
        chk("ill_ld_lat", lat, 1);
        chk("ill_ld_err", last_err, 1);
        chk("ill_ld_rd", rd, 32'h80FF7F01);
        run_op(0, 1, 3'b100, 9'h020, 32'hCAFEF00D, 0, 0, lat);
        chk("ill_st_lat", lat, 1);
        chk("ill_st_mem", mem_word(9'h020), 32'h80FF7F01);
        idle(1);

        // Randomized mix of loads, stores and illegal encodings
        for (int t = 0; t < 400; t++) begin
            int sel;
            sel = $urandom_range(2);
            run_op(sel != 1, sel != 0, 3'($urandom), AW'($urandom), $urandom,
                   $urandom_range(2), 1, lat);
            idle($urandom_range(2));
        end

        // Reset while the second half of a split store is pending
        old94 = shadow[9'h094];
        MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010; addr = 9'h093;
        wd = 32'hA1B2C3D4; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("rst_pre_req", mem_req, 1);
        chk("rst_pre_addr", mem_addr, 9'h094);
        #2;
        rst_n = 1'b0;
        rd_model = '0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", rd, 0);
        @(negedge clk);
        MemWrite = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_idle_stall", stall, 0);
        chk("rst_idle_req", mem_req, 0);
        @(negedge clk);
        chk("rst_first_word", mem[9'h093], 8'hD4);
        chk("rst_second_word", mem[9'h094], old94);
        shadow[9'h093] = 8'hD4;
        idle(2);
        run_op(1, 0, 3'b000, 9'h093, 32'h0, 0, 0, lat);
        chk("rst_after_lb", rd, 32'hFFFFFFD4);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator sitting between the core's execute stage and the data memory port. It takes the per-instruction MemRead/MemWrite/Funct3/address/store-data controls, and issues one or two word-aligned byte-enabled memory transactions over a req/ready handshake. It returns sign- or zero-extended load data and stalls the pipeline until the access completes. Misaligned halfword/word accesses that cross a word boundary are split into two transactions.

## Interface
Parameters:
- DM_ADDRESS, 9, byte-address width of data memory
- DATA_W, 32, data width; fixed at 32, with 4 byte lanes

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- Funct3  in  3  instruction bits 14:12; 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  DM_ADDRESS  byte address (ALU result LSBs)
- wd  in  DATA_W  store data, right-aligned
- stall  out  1  holds pipeline; inputs must stay stable while high
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for illegal Funct3
- rd  out  DATA_W  extended load result, valid from done onward
- mem_req  out  1  transaction request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DM_ADDRESS  word-aligned address; bits 1:0 always 0
- mem_be  out  4  byte-lane enables
- mem_wdata  out  DATA_W  lane-aligned write data
- mem_ready  in  1  transaction accepted/completed this cycle
- mem_rdata  in  DATA_W  read word, valid when mem_ready=1

## Operation
- States: IDLE, REQ0, REQ1, RESP. Reset sets state to IDLE and rd to 0. All outputs are 0 in reset.
- IDLE: if MemRead or MemWrite is high, capture op, size, off=addr[1:0], word address, and wd, then go to REQ0. If both are high, the read wins. Otherwise stay in IDLE.
- Illegal Funct3 goes from IDLE directly to RESP with err=1 and no memory transaction. Loads: 011, 110, 111 are illegal. Stores: any value above 010 is illegal.
- Size n is 1, 2 or 4 bytes. Lane mask m = ((1<<n)-1) << off, 7 bits wide. split = |m[6:4].
- REQ0: mem_addr = word address and mem_be = m[3:0]. For stores, mem_wdata = wd << 8*off. On mem_ready, go to REQ1 if split, else RESP.
- REQ1: mem_addr = word address + 4, wrapping modulo 2^DM_ADDRESS. mem_be = m[6:4] zero-extended. For stores, mem_wdata = wd >> 8*(4-off). On mem_ready, go to RESP.
- Load assembly: raw = (rdata0 >> 8*off) | (rdata1 << 8*(4-off)). The rdata1 term applies only when split.
- Load extension: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
- mem_be applies to reads as well; the memory may ignore it.
- RESP: done=1 for one cycle; rd is updated for loads and unchanged for stores and errors. The next state is IDLE unconditionally. Inputs are ignored in RESP, so the still-present instruction is not reissued.
- mem_req=1 and mem_we=op throughout REQ0/REQ1. mem_req=0 in IDLE and RESP.
- mem_addr, mem_be and mem_wdata are held stable while mem_req=1 and mem_ready=0.
- Reset mid-operation aborts the access immediately. If a split store has completed REQ0, that first word stays written.

## Timing
- stall = (state==IDLE & (MemRead|MemWrite)) | state==REQ0 | state==REQ1. It is combinational, so the pipeline freezes in the request cycle.
- stall=0 in RESP, so the pipeline advances on the edge that ends RESP.
- Latency from request cycle to done, with mem_ready tied high: aligned access 2 cycles, split access 3 cycles, illegal Funct3 1 cycle. Each memory wait cycle adds 1.
- The transfer occurs on the rising edge where mem_req & mem_ready. mem_rdata is sampled at that edge.
- rd is registered and holds its value until the next completed load.

## Test plan
- Aligned word store then load: SW with addr=0x010 and wd=0xDEADBEEF gives one REQ0 with be=1111 and wdata=0xDEADBEEF. LW from addr=0x010 returns rd=0xDEADBEEF with done 2 cycles after the request.
- Byte lanes and extension: memory word at 0x020 is 0x80FF7F01. LB from 0x023 gives 0xFFFFFF80. LBU from 0x023 gives 0x00000080. LH from 0x022 gives 0xFFFF80FF. LHU from 0x021 gives 0x0000FF7F. Each read uses mem_addr=0x020.
- Split store: SW with addr=0x013 and wd=0x11223344. REQ0 has mem_addr=0x010, be=1000, wdata[31:24]=0x44. REQ1 has mem_addr=0x014, be=0111, wdata[23:0]=0x112233. done arrives 3 cycles after the request.
- Split load with wrap: LH from 0x1FF (DM_ADDRESS=9), where byte 0x1FF=0x34 and byte 0x000=0x92. Accesses go to 0x1FC then 0x000, and rd=0xFFFF9234.
- Handshake and stall: hold mem_ready low for 3 cycles during REQ0. mem_addr, mem_be and mem_wdata stay stable and stall stays 1. done occurs exactly 1 cycle after mem_ready.
- Corner cases:
  - MemRead and MemWrite both high: a read is issued.
  - Funct3=011 load: err and done in the cycle after the request, with no mem_req.
  - rst_n low during REQ1: mem_req, stall and done go to 0 immediately, and the state returns to IDLE.
